// File: rtl/mhd_pkg.sv
// Shared definitions for the mhd (maximum-Hamming-distance) checking blocks.
package mhd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mhd_state_e;

  localparam int unsigned MHD_WIDTH_DEF = 9;
  localparam int unsigned MHD_MHD_DEF   = 4;
  localparam int unsigned MHD_CNT_W_DEF = 16;

  function automatic int unsigned hd_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mhd_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module mhd_popcount
  import mhd_pkg::*;
#(
  parameter int unsigned WIDTH = MHD_WIDTH_DEF,
  parameter int unsigned HD_W  = hd_width(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [HD_W-1:0]  cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_o = cnt_o + HD_W'(vec_i[i]);
    end
  end

endmodule

// File: rtl/mhd_err_monitor.sv
// Streams exact/approximate output-vector pairs through an XOR/popcount/threshold
// pipeline and accumulates per-run error statistics with a pass/fail verdict.
module mhd_err_monitor
  import mhd_pkg::*;
#(
  parameter int unsigned WIDTH = MHD_WIDTH_DEF,
  parameter int unsigned MHD   = MHD_MHD_DEF,
  parameter int unsigned CNT_W = MHD_CNT_W_DEF,
  parameter int unsigned HD_W  = hd_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [CNT_W-1:0] err_budget,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             viol,
  output logic [HD_W-1:0]  viol_hd,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [HD_W-1:0]  max_hd,
  output logic             busy,
  output logic             done,
  output logic             fail
);

  localparam logic [HD_W-1:0] MHD_V = HD_W'(MHD);

  mhd_state_e       state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] budget_q, budget_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_diff_q, s1_diff_d;
  logic             viol_q, viol_d;
  logic [HD_W-1:0]  hd_q, hd_d;
  logic [HD_W-1:0]  max_q, max_d;
  logic [CNT_W-1:0] smp_q, smp_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             fail_q, fail_d;
  logic [HD_W-1:0]  pc;
  logic             accept;
  logic             start_ok;

  // in_ready decodes only the registered state, so in_valid never feeds back into it
  assign in_ready = (state_q == RUN);
  assign accept   = in_valid && in_ready;
  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));

  mhd_popcount #(
    .WIDTH (WIDTH),
    .HD_W  (HD_W)
  ) u_popcount (
    .vec_i (s1_diff_q),
    .cnt_o (pc)
  );

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    budget_d = budget_q;
    acc_d    = acc_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          num_d    = num_vec;
          budget_d = err_budget;
          acc_d    = '0;
          state_d  = (num_vec == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          acc_d = acc_q + CNT_W'(1);
          if (acc_d == num_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!s1_valid_q) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s1_valid_d = accept;
    s1_diff_d  = accept ? (a ^ b) : s1_diff_q;
    viol_d     = 1'b0;
    hd_d       = hd_q;
    max_d      = max_q;
    smp_d      = smp_q;
    err_d      = err_q;
    fail_d     = fail_q;
    if (start_ok) begin
      smp_d  = '0;
      err_d  = '0;
      max_d  = '0;
      fail_d = 1'b0;
    end else if (s1_valid_q) begin
      hd_d   = pc;
      viol_d = (pc > MHD_V);
      smp_d  = smp_q + CNT_W'(1);
      if (viol_d && (err_q != '1)) begin
        err_d = err_q + CNT_W'(1);
      end
      if (pc > max_q) begin
        max_d = pc;
      end
    end
    // Stage 1 is empty on the DRAIN->DONE edge, so err_q is already final here
    if ((state_q == DRAIN) && !s1_valid_q) begin
      fail_d = (err_q > budget_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      num_q      <= '0;
      budget_q   <= '0;
      acc_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_diff_q  <= '0;
      viol_q     <= 1'b0;
      hd_q       <= '0;
      max_q      <= '0;
      smp_q      <= '0;
      err_q      <= '0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      budget_q   <= budget_d;
      acc_q      <= acc_d;
      s1_valid_q <= s1_valid_d;
      s1_diff_q  <= s1_diff_d;
      viol_q     <= viol_d;
      hd_q       <= hd_d;
      max_q      <= max_d;
      smp_q      <= smp_d;
      err_q      <= err_d;
      fail_q     <= fail_d;
    end
  end

  assign viol       = viol_q;
  assign viol_hd    = hd_q;
  assign sample_cnt = smp_q;
  assign err_cnt    = err_q;
  assign max_hd     = max_q;
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign fail       = fail_q;

endmodule

// File: tb/tb_mhd_err_monitor.sv
// Directed bench for mhd_err_monitor: default instance plus a CNT_W=4 instance for saturation.
module tb_mhd_err_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_vec = '0;
  logic [15:0] err_budget = '0;
  logic        in_valid = 1'b0;
  logic [8:0]  a = '0;
  logic [8:0]  b = '0;
  logic        in_ready, viol, busy, done, fail;
  logic [3:0]  viol_hd, max_hd;
  logic [15:0] sample_cnt, err_cnt;

  logic        s_start = 1'b0;
  logic [3:0]  s_num = '0;
  logic [3:0]  s_budget = '0;
  logic        s_in_ready, s_viol, s_busy, s_done, s_fail;
  logic [3:0]  s_viol_hd, s_max_hd, s_sample, s_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mhd_err_monitor #(
    .WIDTH (9),
    .MHD   (4),
    .CNT_W (16)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_vec    (num_vec),
    .err_budget (err_budget),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .viol       (viol),
    .viol_hd    (viol_hd),
    .sample_cnt (sample_cnt),
    .err_cnt    (err_cnt),
    .max_hd     (max_hd),
    .busy       (busy),
    .done       (done),
    .fail       (fail)
  );

  mhd_err_monitor #(
    .WIDTH (9),
    .MHD   (4),
    .CNT_W (4)
  ) u_sat (
    .clk        (clk),
    .rst        (rst),
    .start      (s_start),
    .num_vec    (s_num),
    .err_budget (s_budget),
    .in_valid   (in_valid),
    .in_ready   (s_in_ready),
    .a          (a),
    .b          (b),
    .viol       (s_viol),
    .viol_hd    (s_viol_hd),
    .sample_cnt (s_sample),
    .err_cnt    (s_err),
    .max_hd     (s_max_hd),
    .busy       (s_busy),
    .done       (s_done),
    .fail       (s_fail)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 32'(in_ready), 0);
    chk({tag, "_viol"}, 32'(viol), 0);
    chk({tag, "_hd"}, 32'(viol_hd), 0);
    chk({tag, "_smp"}, 32'(sample_cnt), 0);
    chk({tag, "_err"}, 32'(err_cnt), 0);
    chk({tag, "_max"}, 32'(max_hd), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_fail"}, 32'(fail), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] pat;
    logic [8:0] v;

    // reset state
    #1 rst = 1'b1;
    tick();
    tick();
    chk_idle("rst");
    rst = 1'b0;
    tick();

    // threshold boundary, budget 2
    start = 1'b1; num_vec = 16'd3; err_budget = 16'd2;
    in_valid = 1'b1; a = 9'h000; b = 9'h00F;
    tick();
    start = 1'b0;
    chk("thr_ready", 32'(in_ready), 1);
    chk("thr_busy", 32'(busy), 1);
    tick();
    a = 9'h000; b = 9'h01F;
    tick();
    chk("thr_hd0", 32'(viol_hd), 4);
    chk("thr_v0", 32'(viol), 0);
    chk("thr_smp0", 32'(sample_cnt), 1);
    a = 9'h1FF; b = 9'h000;
    tick();
    chk("thr_hd1", 32'(viol_hd), 5);
    chk("thr_v1", 32'(viol), 1);
    chk("thr_err1", 32'(err_cnt), 1);
    chk("thr_ready_drain", 32'(in_ready), 0);
    chk("thr_busy_drain", 32'(busy), 1);
    in_valid = 1'b0;
    tick();
    chk("thr_hd2", 32'(viol_hd), 9);
    chk("thr_v2", 32'(viol), 1);
    chk("thr_done_early", 32'(done), 0);
    tick();
    chk("thr_done", 32'(done), 1);
    chk("thr_busy_done", 32'(busy), 0);
    chk("thr_v_idle", 32'(viol), 0);
    chk("thr_err", 32'(err_cnt), 2);
    chk("thr_max", 32'(max_hd), 9);
    chk("thr_smp", 32'(sample_cnt), 3);
    chk("thr_fail_b2", 32'(fail), 0);
    tick();
    chk("thr_done_hold", 32'(done), 1);
    chk("thr_err_hold", 32'(err_cnt), 2);

    // restart from DONE with budget 1; a start mid-RUN must be ignored
    start = 1'b1; num_vec = 16'd3; err_budget = 16'd1;
    in_valid = 1'b1; a = 9'h000; b = 9'h00F;
    tick();
    start = 1'b0;
    chk("rs_smp_clr", 32'(sample_cnt), 0);
    chk("rs_err_clr", 32'(err_cnt), 0);
    chk("rs_max_clr", 32'(max_hd), 0);
    chk("rs_fail_clr", 32'(fail), 0);
    chk("rs_done_clr", 32'(done), 0);
    tick();
    start = 1'b1; num_vec = 16'd0; a = 9'h000; b = 9'h01F;
    tick();
    start = 1'b0; num_vec = 16'd3;
    chk("rs_ign_smp", 32'(sample_cnt), 1);
    chk("rs_ign_ready", 32'(in_ready), 1);
    a = 9'h1FF; b = 9'h000;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("rs_done", 32'(done), 1);
    chk("rs_err", 32'(err_cnt), 2);
    chk("rs_max", 32'(max_hd), 9);
    chk("rs_smp", 32'(sample_cnt), 3);
    chk("rs_fail_b1", 32'(fail), 1);

    // handshake gaps, 5 accepts from pattern 1,0,1,1,0,0,1,1
    pat = 8'b1100_1101;
    start = 1'b1; num_vec = 16'd5; err_budget = 16'd0; in_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = pat[i];
      if (pat[i]) begin
        v = 9'($urandom);
        a = v; b = v;
      end else begin
        a = 9'h000; b = 9'h1FF;
      end
      chk("gap_ready", 32'(in_ready), 1);
      tick();
    end
    chk("gap_ready_after5", 32'(in_ready), 0);
    a = 9'h000; b = 9'h1FF;
    tick();
    chk("gap_smp_drain", 32'(sample_cnt), 5);
    tick();
    chk("gap_done", 32'(done), 1);
    chk("gap_smp", 32'(sample_cnt), 5);
    chk("gap_err", 32'(err_cnt), 0);
    chk("gap_max", 32'(max_hd), 0);
    chk("gap_fail", 32'(fail), 0);
    in_valid = 1'b0;

    // zero-length run
    start = 1'b1; num_vec = 16'd0; err_budget = 16'd0;
    in_valid = 1'b1; a = 9'h000; b = 9'h1FF;
    tick();
    start = 1'b0;
    chk("zero_ready0", 32'(in_ready), 0);
    chk("zero_busy", 32'(busy), 1);
    tick();
    chk("zero_done", 32'(done), 1);
    chk("zero_ready1", 32'(in_ready), 0);
    chk("zero_smp", 32'(sample_cnt), 0);
    chk("zero_err", 32'(err_cnt), 0);
    chk("zero_max", 32'(max_hd), 0);
    chk("zero_fail", 32'(fail), 0);

    // asynchronous reset after 3 accepts, then a fresh run
    start = 1'b1; num_vec = 16'd10; err_budget = 16'd0;
    in_valid = 1'b1; a = 9'h000; b = 9'h1FF;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_smp", 32'(sample_cnt), 2);
    chk("mid_viol", 32'(viol), 1);
    rst = 1'b1;
    #2;
    chk_idle("arst");
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk_idle("arst_rel");
    start = 1'b1; num_vec = 16'd1; err_budget = 16'd0;
    in_valid = 1'b1; a = 9'h007; b = 9'h000;
    tick();
    start = 1'b0;
    chk("post_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    tick();
    chk("post_hd", 32'(viol_hd), 3);
    chk("post_viol", 32'(viol), 0);
    tick();
    chk("post_done", 32'(done), 1);
    chk("post_smp", 32'(sample_cnt), 1);
    chk("post_err", 32'(err_cnt), 0);
    chk("post_max", 32'(max_hd), 3);
    chk("post_fail", 32'(fail), 0);

    // saturation on the CNT_W=4 instance
    s_start = 1'b1; s_num = 4'd15; s_budget = 4'd14;
    in_valid = 1'b1; a = 9'h000; b = 9'h1FF;
    tick();
    s_start = 1'b0;
    repeat (15) tick();
    in_valid = 1'b0;
    chk("sat_ready", 32'(s_in_ready), 0);
    chk("sat_err14", 32'(s_err), 14);
    tick();
    chk("sat_err15", 32'(s_err), 15);
    tick();
    chk("sat_done", 32'(s_done), 1);
    chk("sat_err", 32'(s_err), 15);
    chk("sat_smp", 32'(s_sample), 15);
    chk("sat_max", 32'(s_max_hd), 9);
    chk("sat_fail", 32'(s_fail), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
